// File: rtl/pacman_input_ctrl_pkg.sv
// Purpose: shared constants, handshake states and key decode for the player input path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pacman_input_ctrl_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_LEFT  = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam logic [7:0] KEY_UP    = 8'hF7;
  localparam logic [7:0] KEY_LEFT  = 8'hE1;
  localparam logic [7:0] KEY_DOWN  = 8'hF3;
  localparam logic [7:0] KEY_RIGHT = 8'hE4;
  localparam logic [7:0] KEY_PAUSE = 8'hA0;

  typedef enum logic [1:0] {
    HS_IDLE     = 2'd0,
    HS_ACK      = 2'd1,
    HS_WAIT_CLR = 2'd2
  } hs_state_t;

  typedef struct packed {
    logic is_dir;
    logic is_pause;
    dir_t dir;
  } key_dec_t;

  // Arrow keys map to a direction, the pause key to a toggle; anything else decodes to nothing.
  function automatic key_dec_t decode_key(input logic [7:0] code);
    key_dec_t d;
    d = '0;
    case (code)
      KEY_UP:    begin d.is_dir = 1'b1; d.dir = DIR_UP;    end
      KEY_LEFT:  begin d.is_dir = 1'b1; d.dir = DIR_LEFT;  end
      KEY_DOWN:  begin d.is_dir = 1'b1; d.dir = DIR_DOWN;  end
      KEY_RIGHT: begin d.is_dir = 1'b1; d.dir = DIR_RIGHT; end
      KEY_PAUSE: d.is_pause = 1'b1;
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pacman_input_ctrl_if.sv
// Purpose: bundles the keyboard handshake, frame/pop controls and rotation outputs.
// Latency: n/a (wiring only).
// Backpressure: keycode is held by the producer until keystrobe acknowledges it.
interface pacman_input_ctrl_if;
  import pacman_input_ctrl_pkg::*;

  logic [7:0] keycode;
  logic       keystrobe;
  logic       frame_tick;
  logic       dir_pop;
  dir_t       dir;
  logic       dir_pending;
  logic       pause;
  logic       overflow;

  modport master (
    output keycode, frame_tick, dir_pop,
    input  keystrobe, dir, dir_pending, pause, overflow
  );

  modport slave (
    input  keycode, frame_tick, dir_pop,
    output keystrobe, dir, dir_pending, pause, overflow
  );

endinterface

// File: rtl/pacman_input_ctrl_dir_fifo.sv
// Purpose: small synchronous FIFO of 2-bit turn requests with head and tail visibility.
// Latency: push visible at head/tail the cycle after the write edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module pacman_input_ctrl_dir_fifo
  import pacman_input_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  dir_t push_dat,
  input  logic pop,
  output logic full,
  output logic empty,
  output dir_t head,
  output dir_t tail
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  dir_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A pop frees the slot a same-cycle push needs, so full+push+pop is legal.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign tail    = mem[wr_ptr - PW'(1)];

  // Storage array; contents are don't-care while their slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally; the extra count bit separates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pacman_input_ctrl.sv
// Purpose: acks keycodes, decodes arrows into queued turn requests, ages them, owns pause.
// Latency: key available at N -> keystrobe at N+1 -> dir/dir_pending updated at N+2.
// Backpressure: one key per handshake; requests dropped (sticky overflow) when the queue is full.
module pacman_input_ctrl
  import pacman_input_ctrl_pkg::*;
#(
  parameter int   DEPTH          = 4,
  parameter int   TIMEOUT_FRAMES = 8,
  parameter dir_t INIT_DIR       = 2'd1
) (
  input logic                clk,
  input logic                reset,
  pacman_input_ctrl_if.slave bus
);

  localparam int AW = $clog2(TIMEOUT_FRAMES + 1);

  hs_state_t     state;
  hs_state_t     state_nxt;
  logic [7:0]    code_q;
  key_dec_t      dec;
  dir_t          committed;
  logic [AW-1:0] age;
  logic          pause_q;
  logic          overflow_q;

  logic          in_ack;
  logic          push_req;
  logic          pop_eff;
  logic          tick_eff;
  logic          expire;
  logic          fifo_pop;
  logic          full;
  logic          empty;
  dir_t          head;
  dir_t          tail;

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) state <= HS_IDLE;
    else       state <= state_nxt;
  end

  // Handshake next state: ack once, then wait for the producer to drop the key.
  always_comb begin
    state_nxt = state;
    case (state)
      HS_IDLE:     if (bus.keycode[7]) state_nxt = HS_ACK;
      HS_ACK:      state_nxt = HS_WAIT_CLR;
      HS_WAIT_CLR: if (!bus.keycode[7]) state_nxt = HS_IDLE;
      default:     state_nxt = HS_IDLE;
    endcase
  end

  // Capture the code as it is accepted so decode sees a stable value in the ack cycle.
  always_ff @(posedge clk) begin
    if (reset)                              code_q <= '0;
    else if (state == HS_IDLE && bus.keycode[7]) code_q <= bus.keycode;
  end

  assign in_ack        = (state == HS_ACK);
  assign bus.keystrobe = in_ack;
  assign dec           = decode_key(code_q);

  // A repeat of the newest outstanding request (or of the committed dir when idle) adds nothing.
  assign push_req = in_ack && dec.is_dir && !pause_q &&
                    (empty ? (dec.dir != committed) : (dec.dir != tail));
  assign pop_eff  = bus.dir_pop && !empty;
  assign tick_eff = bus.frame_tick && !empty && !pause_q;
  assign expire   = tick_eff && !pop_eff && (age >= AW'(TIMEOUT_FRAMES - 1));
  assign fifo_pop = pop_eff || expire;

  pacman_input_ctrl_dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_req),
    .push_dat (dec.dir),
    .pop      (fifo_pop),
    .full     (full),
    .empty    (empty),
    .head     (head),
    .tail     (tail)
  );

  // Committed direction follows the consumer; expired requests never commit.
  always_ff @(posedge clk) begin
    if (reset)        committed <= INIT_DIR;
    else if (pop_eff) committed <= head;
  end

  // Head age in frames; restarts whenever a new request becomes the head.
  always_ff @(posedge clk) begin
    if (reset)                        age <= '0;
    else if (fifo_pop)                age <= '0;
    else if (push_req && empty)       age <= '0;
    else if (tick_eff && age != AW'(TIMEOUT_FRAMES)) age <= age + AW'(1);
  end

  // Pause toggle and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (in_ack && dec.is_pause)         pause_q    <= ~pause_q;
      if (push_req && full && !fifo_pop)  overflow_q <= 1'b1;
    end
  end

  assign bus.dir         = empty ? committed : head;
  assign bus.dir_pending = !empty;
  assign bus.pause       = pause_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Purpose: directed checks of handshake, queueing, dedup, ageing, full+pop and pause/reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_pacman_input_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   strobes = 0;

  always #5 clk = ~clk;

  pacman_input_ctrl_if bus();

  pacman_input_ctrl #(.DEPTH(4), .TIMEOUT_FRAMES(8), .INIT_DIR(2'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Count acknowledge pulses as seen at each rising edge.
  always @(posedge clk) if (bus.keystrobe === 1'b1) strobes++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.keycode = 8'h00; bus.frame_tick = 1'b0; bus.dir_pop = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press(input logic [7:0] c);
    bus.keycode = c;
    repeat (3) tick();
    bus.keycode = 8'h00;
    repeat (2) tick();
  endtask

  task automatic pop1();
    bus.dir_pop = 1'b1; tick(); bus.dir_pop = 1'b0;
  endtask

  task automatic frame1();
    bus.frame_tick = 1'b1; tick(); bus.frame_tick = 1'b0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.keystrobe !== 1'b0) begin bad++; $display("FAIL rst_keystrobe got=%0d exp=0", bus.keystrobe); end
    total++; if (bus.dir !== 2'd1) begin bad++; $display("FAIL rst_dir got=%0d exp=1", bus.dir); end
    total++; if (bus.dir_pending !== 1'b0) begin bad++; $display("FAIL rst_pending got=%0d exp=0", bus.dir_pending); end
    total++; if (bus.pause !== 1'b0) begin bad++; $display("FAIL rst_pause got=%0d exp=0", bus.pause); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0d exp=0", bus.overflow); end
  endtask

  task automatic test_handshake();
    int s0;
    s0 = strobes;
    bus.keycode = 8'hF7;
    tick();
    total++; if (bus.keystrobe !== 1'b1) begin bad++; $display("FAIL hs_strobe_n1 got=%0d exp=1", bus.keystrobe); end
    total++; if (bus.dir !== 2'd1) begin bad++; $display("FAIL hs_dir_n1 got=%0d exp=1", bus.dir); end
    tick();
    total++; if (bus.keystrobe !== 1'b0) begin bad++; $display("FAIL hs_strobe_n2 got=%0d exp=0", bus.keystrobe); end
    total++; if (bus.dir !== 2'd0) begin bad++; $display("FAIL hs_dir_n2 got=%0d exp=0", bus.dir); end
    total++; if (bus.dir_pending !== 1'b1) begin bad++; $display("FAIL hs_pending_n2 got=%0d exp=1", bus.dir_pending); end
    repeat (8) tick();
    bus.keycode = 8'h00;
    tick(); tick();
    total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL hs_pulse_count got=%0d exp=1", strobes - s0); end
  endtask

  task automatic test_overflow();
    logic [1:0] seq [4];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    press(8'hF7); pop1();
    total++; if (bus.dir !== 2'd0 || bus.dir_pending !== 1'b0) begin bad++; $display("FAIL ovf_setup got=%0d/%0d exp=0/0", bus.dir, bus.dir_pending); end
    press(8'hE1); press(8'hF3); press(8'hE4); press(8'hF7);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%0d exp=0", bus.overflow); end
    press(8'hE1);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_after got=%0d exp=1", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.dir !== seq[i] || bus.dir_pending !== 1'b1) begin bad++; $display("FAIL ovf_seq%0d got=%0d/%0d exp=%0d/1", i, bus.dir, bus.dir_pending, seq[i]); end
      pop1();
    end
    total++; if (bus.dir !== 2'd0 || bus.dir_pending !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0d/%0d exp=0/0", bus.dir, bus.dir_pending); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d exp=1", bus.overflow); end
  endtask

  task automatic test_duplicate();
    int s0;
    do_reset();
    s0 = strobes;
    press(8'hE1);
    total++; if (bus.dir_pending !== 1'b0) begin bad++; $display("FAIL dup_vs_committed got=%0d exp=0", bus.dir_pending); end
    total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL dup_acked_empty got=%0d exp=1", strobes - s0); end
    press(8'hF7); pop1();
    s0 = strobes;
    press(8'hE1); press(8'hE1);
    total++; if (strobes - s0 !== 2) begin bad++; $display("FAIL dup_acks got=%0d exp=2", strobes - s0); end
    total++; if (bus.dir !== 2'd1 || bus.dir_pending !== 1'b1) begin bad++; $display("FAIL dup_head got=%0d/%0d exp=1/1", bus.dir, bus.dir_pending); end
    pop1();
    total++; if (bus.dir_pending !== 1'b0 || bus.dir !== 2'd1) begin bad++; $display("FAIL dup_single got=%0d/%0d exp=0/1", bus.dir_pending, bus.dir); end
  endtask

  task automatic test_timeout();
    do_reset();
    press(8'hF3);
    total++; if (bus.dir !== 2'd2 || bus.dir_pending !== 1'b1) begin bad++; $display("FAIL to_pushed got=%0d/%0d exp=2/1", bus.dir, bus.dir_pending); end
    repeat (7) frame1();
    total++; if (bus.dir !== 2'd2 || bus.dir_pending !== 1'b1) begin bad++; $display("FAIL to_tick7 got=%0d/%0d exp=2/1", bus.dir, bus.dir_pending); end
    frame1();
    total++; if (bus.dir !== 2'd1 || bus.dir_pending !== 1'b0) begin bad++; $display("FAIL to_tick8 got=%0d/%0d exp=1/0", bus.dir, bus.dir_pending); end
  endtask

  task automatic test_full_pop();
    logic [1:0] seq [4];
    seq = '{2'd2, 2'd3, 2'd1, 2'd0};
    do_reset();
    press(8'hF7); press(8'hF3); press(8'hE4); press(8'hE1);
    total++; if (bus.dir !== 2'd0) begin bad++; $display("FAIL fp_head got=%0d exp=0", bus.dir); end
    bus.keycode = 8'hF7;
    tick();
    total++; if (bus.keystrobe !== 1'b1) begin bad++; $display("FAIL fp_strobe got=%0d exp=1", bus.keystrobe); end
    bus.dir_pop = 1'b1;
    tick();
    bus.dir_pop = 1'b0; bus.keycode = 8'h00;
    tick(); tick();
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fp_overflow got=%0d exp=0", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.dir !== seq[i] || bus.dir_pending !== 1'b1) begin bad++; $display("FAIL fp_seq%0d got=%0d/%0d exp=%0d/1", i, bus.dir, bus.dir_pending, seq[i]); end
      pop1();
    end
    total++; if (bus.dir_pending !== 1'b0 || bus.dir !== 2'd0) begin bad++; $display("FAIL fp_drained got=%0d/%0d exp=0/0", bus.dir_pending, bus.dir); end
  endtask

  task automatic test_pause();
    int s0;
    do_reset();
    press(8'hF3);
    press(8'hA0);
    total++; if (bus.pause !== 1'b1) begin bad++; $display("FAIL pz_on got=%0d exp=1", bus.pause); end
    press(8'hE4);
    repeat (10) frame1();
    total++; if (bus.dir !== 2'd2 || bus.dir_pending !== 1'b1) begin bad++; $display("FAIL pz_frozen got=%0d/%0d exp=2/1", bus.dir, bus.dir_pending); end
    press(8'hA0);
    total++; if (bus.pause !== 1'b0) begin bad++; $display("FAIL pz_off got=%0d exp=0", bus.pause); end
    pop1();
    total++; if (bus.dir_pending !== 1'b0 || bus.dir !== 2'd2) begin bad++; $display("FAIL pz_e4_ignored got=%0d/%0d exp=0/2", bus.dir_pending, bus.dir); end
    press(8'hA0);
    bus.keycode = 8'hE4;
    tick();
    reset = 1'b1;
    tick(); tick();
    s0 = strobes;
    total++; if (bus.keystrobe !== 1'b0) begin bad++; $display("FAIL mr_keystrobe got=%0d exp=0", bus.keystrobe); end
    total++; if (bus.dir !== 2'd1 || bus.dir_pending !== 1'b0) begin bad++; $display("FAIL mr_dir got=%0d/%0d exp=1/0", bus.dir, bus.dir_pending); end
    total++; if (bus.pause !== 1'b0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL mr_flags got=%0d/%0d exp=0/0", bus.pause, bus.overflow); end
    reset = 1'b0;
    repeat (6) tick();
    total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL mr_reack got=%0d exp=1", strobes - s0); end
    total++; if (bus.dir !== 2'd3 || bus.dir_pending !== 1'b1) begin bad++; $display("FAIL mr_push got=%0d/%0d exp=3/1", bus.dir, bus.dir_pending); end
    bus.keycode = 8'h00;
    tick(); tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.keycode = 8'h00; bus.frame_tick = 1'b0; bus.dir_pop = 1'b0;
    test_reset();
    test_handshake();
    test_overflow();
    test_duplicate();
    test_timeout();
    test_full_pop();
    test_pause();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
